add_roundkey_seq: RTL and testbench
===================================

Name: add_roundkey_seq

Overview:
Parametrised, sequential AddRoundKey engine for the AES datapath; generalises the combinational 4-column XOR stage.
- Accepts one state plus one round key over a valid/ready handshake.
- XORs LANES columns per clock over NB/LANES cycles, then holds the result under a valid/ready output handshake.
- Sits between the round-key source and the next round stage; lets area/latency be traded via LANES.

Parameters:
NB, 4, columns per state (32-bit words); must be >= 1.
LANES, 1, columns XORed per cycle; 1 <= LANES <= NB and NB % LANES == 0; otherwise elaboration error.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  state_in/key_in valid
in_ready  output  1  block can accept a transaction
state_in  input  NB*32  state bytes; byte 0 = bits [NB*32-1 -: 8], byte b = bits [NB*32-1-8b -: 8]
key_in  input  NB*32  round key words; word c = bits [NB*32-1-32c -: 32]
out_valid  output  1  state_out holds a completed result
out_ready  input  1  downstream accepts result
state_out  output  NB*32  result, same byte ordering as state_in
busy  output  1  high in BUSY and DONE

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous, active-high.
- Reset values: FSM = IDLE; in_ready=1; out_valid=0; busy=0; state_out=0; key register=0; col_idx=0.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch state_in into the work register (drives state_out) and key_in into the key register; col_idx=0; go BUSY.
- BUSY:
  - in_ready=0.
  - Each edge, for lanes l=0..LANES-1 with c = col_idx*LANES+l: work bytes 4c..4c+3 ^= key word c bytes [31:24],[23:16],[15:8],[7:0] respectively.
  - col_idx increments. When col_idx == NB/LANES-1 at the edge, go DONE and col_idx=0.
  - in_valid ignored.
- DONE:
  - out_valid=1; state_out stable; in_ready=0.
  - On out_valid&&out_ready: go IDLE, out_valid=0.
  - out_ready held low: remain in DONE indefinitely.
- Latency: out_valid rises exactly NB/LANES cycles after the accepting edge (NB=4, LANES=1 -> 4; LANES=4 -> 1).
- No same-cycle output-drain and input-accept; a new transaction is accepted no earlier than the cycle after the output handshake.
- state_out is contractually defined only while out_valid=1; it shows partial results during BUSY.
- With the feature off, state_out retains its last value in IDLE.
- No arithmetic other than bytewise XOR; no carries, widths fixed at NB*32.
- rst asserted in any state: next edge forces reset values; an in-flight transaction is discarded with no output.
- rst and in_valid in the same cycle: reset wins, nothing accepted.
- col_idx width = max(1, clog2(NB/LANES)).

Optional Feature:
ARK_ZEROIZE_EN:
- Defined: on the output handshake edge, the key register and work register are cleared to 0. state_out reads 0 in IDLE, and no key material persists after use.
- Undefined: both registers retain their contents until the next accept or reset.
- Handshake timing is identical either way.

Test Plan:
- NB=4, LANES=1, FIPS-197 App. B round 0:
  - Stimulus: state_in=3243f6a8885a308d313198a2e0370734, key_in=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1.
  - Response: out_valid 4 cycles after accept; state_out=193de3bea0f4e22b9ac68d2ae9f84808; in_ready low during BUSY/DONE.
- Same vectors with LANES=2 and LANES=4 -> identical result, latency 2 and 1 cycles.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, second in_valid held high.
  - Response: state_out stable, in_ready=0, second transaction accepted only in the cycle after out_ready=1 handshake.
- Reset mid-operation: rst pulsed on the 2nd BUSY cycle -> next cycle out_valid=0, in_ready=1, state_out=0; a following transaction yields the correct result.
- Identity and all-ones:
  - key_in=0 -> state_out=state_in.
  - key_in=all-ones -> state_out=~state_in; NB=8 instance covers a 256-bit state.
- ARK_ZEROIZE_EN defined: after the output handshake, state_out=0 in IDLE; undefined: state_out still 193de3be...4808.

Source files
------------

// File: rtl/add_roundkey_seq.sv
// Sequential AES AddRoundKey: XORs LANES 32-bit columns per cycle. Optional ARK_ZEROIZE_EN clears key/work regs on drain.
// Latency: out_valid rises NB/LANES cycles after the accepting edge.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module add_roundkey_seq #(
  parameter int NB    = 4,
  parameter int LANES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NB*32-1:0] state_in,
  input  logic [NB*32-1:0] key_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NB*32-1:0] state_out,
  output logic            busy
);

  localparam int STEPS = (LANES > 0) ? NB / LANES : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (NB < 1 || LANES < 1 || LANES > NB || (NB % LANES) != 0) begin : g_bad_param
      $error("add_roundkey_seq: need NB >= 1, 1 <= LANES <= NB and NB %% LANES == 0");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [NB*32-1:0] work_q, work_d;
  logic [NB*32-1:0] key_q, key_d;
  logic [CW-1:0]    col_q, col_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      key_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      key_q   <= key_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    key_d   = key_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          key_d   = key_in;
          col_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Column c occupies the same bit window in both the state and the key.
        for (int l = 0; l < LANES; l++) begin
          work_d[NB*32-1-32*(int'(col_q)*LANES+l) -: 32] =
            work_q[NB*32-1-32*(int'(col_q)*LANES+l) -: 32] ^
            key_q[NB*32-1-32*(int'(col_q)*LANES+l) -: 32];
        end
        if (col_q == CW'(STEPS-1)) begin
          col_d   = '0;
          state_d = DONE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef ARK_ZEROIZE_EN
          work_d  = '0;
          key_d   = '0;
`else
          work_d  = work_q;
          key_d   = key_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign state_out = work_q;

endmodule

// File: tb/tb_add_roundkey_seq.sv
// Bench for add_roundkey_seq: three NB=4 instances (LANES 1/2/4) sharing inputs, plus an NB=8 LANES=2 instance.
module tb_add_roundkey_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic [127:0] key_in = '0;
  logic         ir[3];
  logic         ov[3];
  logic         bz[3];
  logic [127:0] so[3];

  logic         v8 = 1'b0;
  logic         r8 = 1'b0;
  logic [255:0] s8 = '0;
  logic [255:0] k8 = '0;
  logic         ir8, ov8, bz8;
  logic [255:0] so8;

  int steps[3] = '{4, 2, 1};
  int ncmp = 0;
  int nfail = 0;

  int           lat[3];
  logic [127:0] res[3];
  logic [127:0] idle_res[3];
  logic         busy_ok[3];

  typedef struct {
    logic [127:0] s;
    logic [127:0] k;
    logic [127:0] e;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  add_roundkey_seq #(.NB(4), .LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .state_in(state_in),
    .key_in(key_in), .out_valid(ov[0]), .out_ready(out_ready), .state_out(so[0]), .busy(bz[0]));
  add_roundkey_seq #(.NB(4), .LANES(2)) dut_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .state_in(state_in),
    .key_in(key_in), .out_valid(ov[1]), .out_ready(out_ready), .state_out(so[1]), .busy(bz[1]));
  add_roundkey_seq #(.NB(4), .LANES(4)) dut_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .state_in(state_in),
    .key_in(key_in), .out_valid(ov[2]), .out_ready(out_ready), .state_out(so[2]), .busy(bz[2]));
  add_roundkey_seq #(.NB(8), .LANES(2)) dut_nb8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .state_in(s8),
    .key_in(k8), .out_valid(ov8), .out_ready(r8), .state_out(so8), .busy(bz8));

  task automatic chk_int(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a transaction at a negedge; returns at the negedge after the accepting edge.
  task automatic start(input logic [127:0] s, input logic [127:0] k, input bit keep);
    state_in = s;
    key_in   = k;
    in_valid = 1'b1;
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  // k=0 is the negedge right after the accepting edge; latency is the first k with out_valid.
  task automatic watch();
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      busy_ok[i] = 1'b1;
      res[i] = '0;
    end
    for (int k = 0; k <= 8; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && lat[i] == 0 && k > 0) begin
          lat[i] = k;
          res[i] = so[i];
        end
        if ((lat[i] == 0 || lat[i] == k) && (ir[i] !== 1'b0 || bz[i] !== 1'b1)) busy_ok[i] = 1'b0;
      end
      if (k < 8) @(negedge clk);
    end
    for (int i = 0; i < 3; i++) idle_res[i] = so[i];
  endtask

  task automatic run8(input string name, input logic [255:0] s, input logic [255:0] k,
                      input logic [255:0] e);
    int l8;
    logic [255:0] r;
    l8 = 0;
    r = '0;
    s8 = s;
    k8 = k;
    v8 = 1'b1;
    r8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (ov8 && l8 == 0 && c > 0) begin
        l8 = c;
        r = so8;
      end
      if (c < 8) @(negedge clk);
    end
    chk_int({name, " latency"}, l8, 4);
    chk_vec({name, " result"}, r, e);
  endtask

  initial begin
    logic [127:0] idle_exp;
    bit stable_ok;

    tbl[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h193de3bea0f4e22b9ac68d2ae9f84808};
    tbl[1] = '{128'h0123456789abcdeffedcba9876543210, 128'h0,
               128'h0123456789abcdeffedcba9876543210};
    tbl[2] = '{128'h3243f6a8885a308d313198a2e0370734, {128{1'b1}},
               128'hcdbc095777a5cf72cece675d1fc8f8cb};
    tbl[3] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h00102030405060708090a0b0c0d0e0f0};

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_int($sformatf("reset in_ready L%0d", 4 / steps[i]), int'(ir[i]), 1);
      chk_int($sformatf("reset out_valid L%0d", 4 / steps[i]), int'(ov[i]), 0);
      chk_int($sformatf("reset busy L%0d", 4 / steps[i]), int'(bz[i]), 0);
      chk_vec($sformatf("reset state_out L%0d", 4 / steps[i]), 256'(so[i]), 256'h0);
    end
    chk_int("reset in_ready NB8", int'(ir8), 1);
    chk_vec("reset state_out NB8", so8, 256'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int v = 0; v < 4; v++) begin
`ifdef ARK_ZEROIZE_EN
      idle_exp = '0;
`else
      idle_exp = tbl[v].e;
`endif
      start(tbl[v].s, tbl[v].k, 1'b0);
      watch();
      for (int i = 0; i < 3; i++) begin
        chk_int($sformatf("vec%0d latency L%0d", v, 4 / steps[i]), lat[i], steps[i]);
        chk_vec($sformatf("vec%0d result L%0d", v, 4 / steps[i]), 256'(res[i]), 256'(tbl[v].e));
        chk_int($sformatf("vec%0d in_ready low L%0d", v, 4 / steps[i]), int'(busy_ok[i]), 1);
        chk_vec($sformatf("vec%0d idle state_out L%0d", v, 4 / steps[i]), 256'(idle_res[i]),
                256'(idle_exp));
      end
    end

    // Backpressure: result must hold while a second request waits.
    out_ready = 1'b0;
    start(tbl[0].s, tbl[0].k, 1'b1);
    state_in = tbl[3].s;
    key_in   = tbl[3].k;
    watch();
    for (int i = 0; i < 3; i++) begin
      chk_int($sformatf("bp latency L%0d", 4 / steps[i]), lat[i], steps[i]);
      chk_vec($sformatf("bp result L%0d", 4 / steps[i]), 256'(res[i]), 256'(tbl[0].e));
    end
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 3; i++)
        if (ov[i] !== 1'b1 || ir[i] !== 1'b0 || so[i] !== tbl[0].e) stable_ok = 1'b0;
      @(negedge clk);
    end
    chk_int("bp hold stable", int'(stable_ok), 1);
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_int($sformatf("bp drain in_ready L%0d", 4 / steps[i]), int'(ir[i]), 1);
      chk_int($sformatf("bp drain busy L%0d", 4 / steps[i]), int'(bz[i]), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    watch();
    for (int i = 0; i < 3; i++) begin
      chk_int($sformatf("bp second latency L%0d", 4 / steps[i]), lat[i], steps[i]);
      chk_vec($sformatf("bp second result L%0d", 4 / steps[i]), 256'(res[i]), 256'(tbl[3].e));
    end

    // Reset on the second BUSY cycle, with a competing request.
    out_ready = 1'b0;
    start(tbl[0].s, tbl[0].k, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    state_in = tbl[3].s;
    key_in = tbl[3].k;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_int($sformatf("rst out_valid L%0d", 4 / steps[i]), int'(ov[i]), 0);
      chk_int($sformatf("rst in_ready L%0d", 4 / steps[i]), int'(ir[i]), 1);
      chk_vec($sformatf("rst state_out L%0d", 4 / steps[i]), 256'(so[i]), 256'h0);
    end
    out_ready = 1'b1;
    start(tbl[0].s, tbl[0].k, 1'b0);
    watch();
    for (int i = 0; i < 3; i++) begin
      chk_int($sformatf("post-rst latency L%0d", 4 / steps[i]), lat[i], steps[i]);
      chk_vec($sformatf("post-rst result L%0d", 4 / steps[i]), 256'(res[i]), 256'(tbl[0].e));
    end

    run8("nb8 ones", {tbl[0].s, tbl[0].s}, {256{1'b1}}, {tbl[2].e, tbl[2].e});
    run8("nb8 mixed", {tbl[3].s, tbl[0].s}, {tbl[3].k, tbl[0].k}, {tbl[3].e, tbl[0].e});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
